// File: rtl/relay_frame_tx.sv
// relay_frame_tx: buffers nibbles in a small FIFO and serializes each one
// as a start(1) / d3..d0 / stop(0) frame at one bit per BIT_DIV clocks.
module relay_frame_tx #(
    parameter int BIT_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [3:0]                    nibble_in,
    input  logic                          nibble_valid,
    output logic                          nibble_ready,
    output logic                          serial_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int CNT_W = $clog2(BIT_DIV);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_DIV - 1);
    localparam logic [CW-1:0]    FULL     = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [1:0]       bit_idx;
    logic [3:0]       shift;

    logic [3:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;

    logic             push;
    logic             pop;
    logic             bit_end;
    logic             can_pop;

    assign push    = nibble_valid & nibble_ready;
    assign bit_end = (bit_cnt == BIT_LAST);
    assign can_pop = enable && (fifo_count != '0);
    // A frame can only be launched from IDLE or at the last clock of STOP,
    // which is what makes enable effective only at frame boundaries.
    assign pop     = can_pop && ((state == IDLE) || ((state == STOP) && bit_end));

    // Next occupancy; push and pop in the same cycle cancel out
    always_comb begin
        count_next = fifo_count + CW'(push) - CW'(pop);
    end

    // FIFO storage write port (contents need no reset, pointers gate validity)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= nibble_in;
        end
    end

    // FIFO pointers, occupancy, registered ready and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            nibble_ready <= 1'b1;
            overflow     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count   <= count_next;
            nibble_ready <= (count_next != FULL);
            if (nibble_valid && !nibble_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // Frame sequencer with registered serial line and busy flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            serial_out <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state      <= START;
                        shift      <= mem[rd_ptr];
                        bit_cnt    <= '0;
                        serial_out <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state      <= DATA;
                        bit_cnt    <= '0;
                        bit_idx    <= '0;
                        serial_out <= shift[3];
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (bit_idx == 2'd3) begin
                            state      <= STOP;
                            serial_out <= 1'b0;
                        end else begin
                            shift      <= {shift[2:0], 1'b0};
                            serial_out <= shift[2];
                            bit_idx    <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            state      <= START;
                            shift      <= mem[rd_ptr];
                            serial_out <= 1'b1;
                        end else begin
                            state      <= IDLE;
                            serial_out <= 1'b0;
                            busy       <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    serial_out <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/relay_frame_tx.md
# relay_frame_tx

Serial frame generator that sits directly upstream of the relay stage. It drives that stage's `data_in` line with real framed nibble traffic, replacing the fixed rotating test pattern. Nibbles written by the ARM-side interface are buffered in a small FIFO and serialized as start / 4 data / stop frames. Bit rate is one bit per `BIT_DIV` clocks, matching the relay decoder's sample rate.

## Interface
Parameters:
- `BIT_DIV`, 16: clk cycles per serial bit; legal values 2..256.
- `FIFO_DEPTH`, 4: nibble entries; power of two, 2..16.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  when high, transmission may start; sampled only at frame boundaries.
- `nibble_in`  in  4  symbol to transmit.
- `nibble_valid`  in  1  write request.
- `nibble_ready`  out  1  FIFO can accept; equals not-full.
- `serial_out`  out  1  registered serial line, to relay `data_in`; idle 0.
- `busy`  out  1  high while a frame is on the line (state ≠ IDLE).
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  entries currently buffered.
- `overflow`  out  1  sticky; set when `nibble_valid` is high while `nibble_ready` is low; cleared only by reset.

## Operation
- Write handshake:
  - A nibble is accepted on a rising edge where `nibble_valid` and `nibble_ready` are both high.
  - `nibble_ready` is low whenever the FIFO is full, even if a pop occurs in the same cycle. There is no bypass.
- Frame format, each bit held exactly `BIT_DIV` cycles:
  - start bit = 1;
  - data bits `d[3]`, `d[2]`, `d[1]`, `d[0]` (MSB first);
  - stop bit = 0.
  - Frame length is 6·`BIT_DIV` cycles.
- States:
  - **IDLE**: `serial_out`=0. If `enable` is high and the FIFO is non-empty: pop the head into the shift register and go to START.
  - **START**: `serial_out`=1 for `BIT_DIV` cycles, then go to DATA with `bit_idx`=0.
  - **DATA**: `serial_out`=shift[3]. Every `BIT_DIV` cycles, shift left. After `bit_idx`=3 completes, go to STOP.
  - **STOP**: `serial_out`=0 for `BIT_DIV` cycles. At the end:
    - if `enable` is high and the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- `enable` falling mid-frame: the frame completes normally and the block then goes to IDLE. FIFO contents are retained.
- Simultaneous push and pop on a non-full FIFO: `fifo_count` is unchanged, and the data order is preserved.
- Bit counter counts 0..`BIT_DIV`-1 and wraps; it is cleared on every state entry.
- Pointers wrap modulo `FIFO_DEPTH`. `fifo_count` ranges 0..`FIFO_DEPTH`.

## Timing
- Reset values:
  - `serial_out`=0, `busy`=0, `nibble_ready`=1, `fifo_count`=0, `overflow`=0;
  - state IDLE, pointers 0.
- Reset mid-frame: the line drops to 0 immediately (asynchronous) and buffered nibbles are discarded.
- Latency with the block in IDLE, `enable` high and FIFO empty, nibble accepted at edge E0:
  - FIFO count becomes 1 at E0;
  - state goes to START and `serial_out` rises at E1;
  - the start bit spans E1..E1+`BIT_DIV`;
  - `fifo_count` returns to 0 at E1.
- `busy` asserts at the same edge as the start bit and deasserts at the same edge the line enters IDLE.
- `nibble_ready` and `fifo_count` are registered and reflect the post-edge occupancy.

## Test plan
- Single frame:
  - stimulus: `BIT_DIV`=16, `enable`=1, write 0xA;
  - response: `serial_out` reads 1,1,0,1,0,0, each for 16 cycles starting one cycle after acceptance;
  - `busy` is high for exactly 96 cycles, then `fifo_count`=0.
- Back-to-back:
  - stimulus: write 0x3 then 0xC;
  - response: 192 contiguous busy cycles with pattern 1,0,0,1,1,0 then 1,1,1,0,0,0, and no idle cycle between the frames.
- Full/overflow:
  - stimulus: `enable`=0, write 5 nibbles;
  - response: the first 4 are accepted, `nibble_ready`=0 after the 4th, `fifo_count`=4, and `overflow`=1 on the 5th attempt.
  - Then raise `enable`: the 4 frames go out in FIFO order and `nibble_ready` returns high after the first pop.
- Enable drop:
  - stimulus: 2 nibbles queued, drop `enable` 20 cycles into frame 1;
  - response: frame 1 completes at 96 cycles, the line idles at 0, `fifo_count`=1.
  - Re-enable: frame 2 starts one cycle later.
- Async reset mid-DATA:
  - stimulus: assert `reset` low asynchronously mid-DATA;
  - response: all outputs are at reset values before the next edge.
  - A fresh write afterwards yields a correct frame.
- Simultaneous push/pop:
  - stimulus: FIFO at count 2, write a nibble on the exact cycle STOP ends;
  - response: count stays 2 and the order is preserved.
